rr_tenure_arbiter: RTL and testbench
====================================

# rr_tenure_arbiter

Round-robin arbiter with bounded tenure for a single shared resource used by `N` requesters. Grants are registered and one-hot. An owner keeps the grant while its request stays high, up to `MAX_HOLD` cycles; the grant is then revoked and priority rotates. It replaces the plain fixed-function arbiter in front of the shared resource and guarantees one dead cycle between owners.

## Interface
- `N`, default 3: number of requesters, at least 2.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure, at least 1.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `r`  in  N: request vector; `r[i]` is level-sensitive and sampled on rising `clk`.
- `g`  out  N: grant vector; registered, one-hot or zero.
- `busy`  out  1: equals `|g`.
- `owner`  out  clog2(N): index of the current or most recent grantee.
- `expired`  out  1: one-cycle pulse after a tenure is cut by `MAX_HOLD`.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - Priority pointer `ptr` (0..N-1).
  - Tenure counter `cnt` (0..MAX_HOLD).
- Arbitration searches `r` starting at index `ptr`, upward with wrap (ptr, ptr+1, …, N-1, 0, …, ptr-1). The first set bit wins.
- **IDLE:**
  - If `r` is nonzero, go to GRANT. Set `g` to the winner's one-hot, set `owner` to the winner, set `cnt` to 1.
  - Otherwise stay in IDLE with `g` = 0.
- **GRANT, `r[owner]` is 0 at the edge (release):**
  - Go to IDLE, `g` = 0, `ptr` = (owner+1) mod N, `expired` = 0.
  - Release takes priority over expiry when both happen on the same edge.
- **GRANT, `r[owner]` is 1 and `cnt` equals MAX_HOLD (expiry):**
  - Go to IDLE, `g` = 0, `ptr` = (owner+1) mod N, `expired` = 1 for the next cycle.
- **GRANT, otherwise:** hold `g`, `cnt` += 1.
- The request bits of non-owners are ignored during GRANT; there is no preemption.
- A tenure always ends through IDLE, so there is exactly one cycle with `g` = 0 between any two grants, including a re-grant to the same requester.
- If only the expired owner is still requesting, it is re-granted after the gap cycle.
- `owner` holds its last value while in IDLE.
- `cnt` width is clog2(MAX_HOLD+1). It never exceeds MAX_HOLD and does not wrap.

## Timing
- Reset values: `g` = 0, `busy` = 0, `owner` = 0, `expired` = 0, `ptr` = 0, `cnt` = 0, state IDLE.
- Asserting `rst` clears all outputs immediately, without waiting for `clk`. This includes reset in the middle of a tenure. The first arbitration after reset starts from `ptr` = 0.
- Grant latency: a request sampled at edge k in IDLE gives `g` high from edge k (visible in cycle k+1).
- Release latency: `r[owner]` low at edge k gives `g` low after edge k.
- Maximum tenure is exactly MAX_HOLD cycles with `g` high.
- `expired` is high exactly during the gap cycle that follows a cut.
- Worst-case wait for a requester that stays high: (N-1)·(MAX_HOLD+1)+1 cycles.
- All outputs are registered; there is no combinational path from `r` to `g`.

## Test plan
All scenarios use N=3, MAX_HOLD=4. `g` is sampled mid-cycle.

1. **Full load rotation.** Reset, then hold `r`=111.
   - `g` must read: 001×4, 000, 010×4, 000, 100×4, 000, 001…
   - `expired` must be 1 in each 000 cycle.
2. **Early release.** Set `r`=010; drop `r[1]` after 2 grant cycles.
   - `g` must read: 010×2, then 000.
   - `expired` stays 0; `owner` stays 1.
3. **Sole requester.** Hold `r`=001 continuously.
   - `g` must read: 001×4, 000 (with `expired`=1), 001×4, repeating.
4. **Rotation after release.** Owner 0 releases while `r`=110.
   - After the gap, `g` must be 010.
   - When requester 1 then releases with `r`=101, after the gap `g` must be 100 (the pointer skips 0).
5. **Release and expiry on the same edge.** Drop `r[owner]` on the same edge that `cnt` reaches 4.
   - `g` must go to 000 with `expired`=0.
6. **Asynchronous reset mid-tenure.** Pulse `rst` between edges during a 010 tenure.
   - `g`, `busy` and `owner` must read 0 before the next edge.
   - After `rst` falls with `r`=100, `g` must be 100 after one edge.

Source files
------------

// File: rtl/rr_tenure_arbiter.sv
// Round-robin arbiter, registered one-hot grant, tenure capped at MAX_HOLD cycles, one idle gap between owners.
// Latency: request seen at edge k is granted from edge k; no backpressure, non-owner requests simply wait.
module rr_tenure_arbiter #(
   parameter int  N        = 3,
   parameter int  MAX_HOLD = 8,
   localparam int OW       = $clog2(N),
   localparam int CW       = $clog2(MAX_HOLD + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  r,
   output logic [N-1:0]  g,
   output logic          busy,
   output logic [OW-1:0] owner,
   output logic          expired
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  g_q, g_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          exp_q, exp_d;
   logic          win_vld;
   logic [OW-1:0] win_idx;
   logic [OW-1:0] owner_inc;

   // First set request at or above ptr, wrapping around to index 0.
   always_comb begin : search
      int            j;
      logic [OW-1:0] idx;
      win_vld = 1'b0;
      win_idx = '0;
      j       = 0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N) j = j - N;
         idx = OW'(j);
         if (!win_vld && r[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
   end

   assign owner_inc = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      exp_d   = 1'b0;
      case (state_q)
         IDLE: begin
            g_d = '0;
            if (win_vld) begin
               state_d          = GRANT;
               g_d[win_idx]     = 1'b1;
               owner_d          = win_idx;
               cnt_d            = CW'(1);
            end
         end
         GRANT: begin
            // Release is tested first so it wins over a simultaneous expiry.
            if (!r[owner_q]) begin
               state_d = IDLE;
               g_d     = '0;
               ptr_d   = owner_inc;
               cnt_d   = '0;
            end else if (cnt_q == CW'(MAX_HOLD)) begin
               state_d = IDLE;
               g_d     = '0;
               ptr_d   = owner_inc;
               cnt_d   = '0;
               exp_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
      end
   end

   assign g       = g_q;
   assign busy    = |g_q;
   assign owner   = owner_q;
   assign expired = exp_q;

endmodule

// File: tb/tb_rr_tenure_arbiter.sv
// Directed scenarios plus random request traffic for rr_tenure_arbiter, checked against a tenure-level model.
module tb_rr_tenure_arbiter;

   localparam int N  = 3;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] r   = '0;
   logic [N-1:0] g;
   logic         busy;
   logic [1:0]   owner;
   logic         expired;

   int vectors    = 0;
   int miscompares = 0;

   // Reference: who owns the resource (-1 = nobody), how long they have held it,
   // where the next search starts, the last grantee and the expiry pulse.
   int m_own  = -1;
   int m_held = 0;
   int m_ptr  = 0;
   int m_last = 0;
   bit m_exp  = 1'b0;

   int s1_g [16] = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 4, 4, 4, 4, 0, 1};
   int s3_g [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   rr_tenure_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .r       (r),
      .g       (g),
      .busy    (busy),
      .owner   (owner),
      .expired (expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_own  = -1;
      m_held = 0;
      m_ptr  = 0;
      m_last = 0;
      m_exp  = 1'b0;
   endtask

   task automatic model_edge(input logic [N-1:0] rv);
      bit found;
      m_exp = 1'b0;
      found = 1'b0;
      if (m_own < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!found && rv[c]) begin
               found  = 1'b1;
               m_own  = c;
               m_last = c;
               m_held = 1;
            end
         end
      end else if (!rv[m_own]) begin
         m_ptr = (m_own + 1) % N;
         m_own = -1;
      end else if (m_held == MH) begin
         m_ptr = (m_own + 1) % N;
         m_own = -1;
         m_exp = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   function automatic int model_g();
      return (m_own < 0) ? 0 : (1 << m_own);
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".g"},       32'(g),       32'(model_g()));
      chk({tag, ".busy"},    32'(busy),    32'(m_own >= 0));
      chk({tag, ".owner"},   32'(owner),   32'(m_last));
      chk({tag, ".expired"}, 32'(expired), 32'(m_exp));
   endtask

   // Drive r, let one rising edge happen, then check on the falling edge.
   task automatic step(input logic [N-1:0] rv, input string tag);
      r = rv;
      @(posedge clk);
      model_edge(rv);
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      logic [N-1:0] rv;

      // Reset state
      #2;
      chk("rst.g", 32'(g), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.owner", 32'(owner), 0);
      chk("rst.expired", 32'(expired), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // 1: full load rotation
      for (int i = 0; i < 16; i++) begin
         step(3'b111, "s1");
         chk("s1.g_seq", 32'(g), 32'(s1_g[i]));
         chk("s1.exp_seq", 32'(expired), 32'(s1_g[i] == 0));
      end
      step(3'b000, "idle");
      step(3'b000, "idle");

      // 2: early release
      step(3'b010, "s2");
      chk("s2.g1", 32'(g), 2);
      step(3'b010, "s2");
      chk("s2.g2", 32'(g), 2);
      step(3'b000, "s2");
      chk("s2.g_rel", 32'(g), 0);
      chk("s2.exp_rel", 32'(expired), 0);
      chk("s2.owner_rel", 32'(owner), 1);

      // 3: sole requester
      for (int i = 0; i < 10; i++) begin
         step(3'b001, "s3");
         chk("s3.g_seq", 32'(g), 32'(s3_g[i]));
         chk("s3.exp_seq", 32'(expired), 32'(s3_g[i] == 0));
      end

      // 4: rotation after release
      step(3'b001, "s4");
      chk("s4.own0", 32'(g), 1);
      step(3'b110, "s4");
      chk("s4.gap1", 32'(g), 0);
      step(3'b110, "s4");
      chk("s4.to1", 32'(g), 2);
      step(3'b101, "s4");
      chk("s4.gap2", 32'(g), 0);
      step(3'b101, "s4");
      chk("s4.to2", 32'(g), 4);

      // 5: release on the expiry edge
      for (int i = 0; i < 3; i++) step(3'b101, "s5");
      chk("s5.hold4", 32'(g), 4);
      step(3'b001, "s5");
      chk("s5.g", 32'(g), 0);
      chk("s5.expired", 32'(expired), 0);

      // 6: asynchronous reset mid-tenure
      step(3'b010, "s6");
      step(3'b010, "s6");
      chk("s6.pre", 32'(g), 2);
      #2 rst = 1'b1;
      #1;
      chk("s6.g", 32'(g), 0);
      chk("s6.busy", 32'(busy), 0);
      chk("s6.owner", 32'(owner), 0);
      #1 rst = 1'b0;
      model_reset();
      step(3'b100, "s6");
      chk("s6.after", 32'(g), 4);

      // Random traffic with sticky requests
      rv = 3'b000;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(3) == 0) rv[b] = ~rv[b];
         step(rv, "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
